// File: rtl/bullet_controller.sv
// Bullet controller: owns one tank's bullet. Spawns it on fire, steps it one
// tile every STEP_FRAMES frame ticks, looks the next tile up in the map store,
// and reports brick destruction or an opponent hit.
module bullet_controller #(
    parameter int STEP_FRAMES = 4,
    parameter int COLS        = 20,
    parameter int ROWS        = 15,
    parameter int PARK        = 31
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [4:0] tank_x,
    input  logic [4:0] tank_y,
    input  logic [1:0] tank_dir,
    input  logic [4:0] opp_x,
    input  logic [4:0] opp_y,
    output logic [8:0] map_rd_idx,
    input  logic [2:0] map_rd_data,
    output logic [4:0] bul_x,
    output logic [4:0] bul_y,
    output logic       bul_active,
    output logic       brk_hit,
    output logic [8:0] brk_idx,
    output logic       tank_hit
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_READ = 2'd2,
        ST_EVAL = 2'd3
    } state_t;

    localparam logic [4:0]        L_PARK  = 5'(PARK);
    localparam logic [3:0]        L_LAST  = 4'(STEP_FRAMES - 1);
    localparam logic signed [5:0] L_COLS  = 6'(COLS);
    localparam logic signed [5:0] L_ROWS  = 6'(ROWS);
    localparam logic [8:0]        L_COLS9 = 9'(COLS);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_dir, w_dir_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [4:0]  r_bul_x, w_bul_x_nxt;
    logic [4:0]  r_bul_y, w_bul_y_nxt;
    logic        r_active, w_active_nxt;
    logic [8:0]  r_map_idx, w_map_idx_nxt;
    logic [8:0]  r_brk_idx, w_brk_idx_nxt;
    logic        r_brk_hit, w_brk_hit_nxt;
    logic        r_tank_hit, w_tank_hit_nxt;
    logic        r_s1, r_s2, r_s3;

    logic               w_tick;
    logic signed [5:0]  w_dx, w_dy;
    logic signed [5:0]  w_nx, w_ny;
    logic               w_oob;
    logic               w_hit_opp;
    logic [8:0]         w_idx;

    // Bring frame_clk into the Clk domain and keep a delayed copy for edge detect.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= frame_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_tick = r_s2 & ~r_s3;

    // Translate the latched heading into a signed one-tile step.
    always_comb begin
        w_dx = 6'sd0;
        w_dy = 6'sd0;
        case (r_dir)
            2'd0:    w_dy = -6'sd1;
            2'd1:    w_dx =  6'sd1;
            2'd2:    w_dy =  6'sd1;
            2'd3:    w_dx = -6'sd1;
            default: w_dx =  6'sd0;
        endcase
    end

    // Signed arithmetic so stepping off the left/top edge yields -1, not a wrap.
    assign w_nx      = $signed({1'b0, r_bul_x}) + w_dx;
    assign w_ny      = $signed({1'b0, r_bul_y}) + w_dy;
    assign w_oob     = (w_nx < 6'sd0) || (w_nx >= L_COLS) ||
                       (w_ny < 6'sd0) || (w_ny >= L_ROWS);
    assign w_hit_opp = (w_nx[4:0] == opp_x) && (w_ny[4:0] == opp_y);
    assign w_idx     = 9'(w_ny[4:0]) * L_COLS9 + 9'(w_nx[4:0]);

    // Next-state and next-output logic for the bullet life cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_dir_nxt      = r_dir;
        w_cnt_nxt      = r_cnt;
        w_bul_x_nxt    = r_bul_x;
        w_bul_y_nxt    = r_bul_y;
        w_active_nxt   = r_active;
        w_map_idx_nxt  = r_map_idx;
        w_brk_idx_nxt  = r_brk_idx;
        w_brk_hit_nxt  = 1'b0;
        w_tank_hit_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fire) begin
                    w_dir_nxt    = tank_dir;
                    w_bul_x_nxt  = tank_x;
                    w_bul_y_nxt  = tank_y;
                    w_active_nxt = 1'b1;
                    w_cnt_nxt    = 4'd0;
                    w_state_nxt  = ST_FLY;
                end else begin
                    w_bul_x_nxt  = L_PARK;
                    w_bul_y_nxt  = L_PARK;
                    w_active_nxt = 1'b0;
                end
            end
            ST_FLY: begin
                if (w_tick) begin
                    if (r_cnt != L_LAST) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_oob) begin
                        w_bul_x_nxt  = L_PARK;
                        w_bul_y_nxt  = L_PARK;
                        w_active_nxt = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end else if (w_hit_opp) begin
                        w_tank_hit_nxt = 1'b1;
                        w_bul_x_nxt    = L_PARK;
                        w_bul_y_nxt    = L_PARK;
                        w_active_nxt   = 1'b0;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_map_idx_nxt = w_idx;
                        w_state_nxt   = ST_READ;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                case (map_rd_data)
                    3'd0, 3'd6: begin
                        w_bul_x_nxt = w_nx[4:0];
                        w_bul_y_nxt = w_ny[4:0];
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = ST_FLY;
                    end
                    3'd2: begin
                        w_brk_hit_nxt = 1'b1;
                        w_brk_idx_nxt = w_idx;
                        w_bul_x_nxt   = L_PARK;
                        w_bul_y_nxt   = L_PARK;
                        w_active_nxt  = 1'b0;
                        w_state_nxt   = ST_IDLE;
                    end
                    default: begin
                        w_bul_x_nxt  = L_PARK;
                        w_bul_y_nxt  = L_PARK;
                        w_active_nxt = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end
                endcase
            end
            default: begin
                w_bul_x_nxt  = L_PARK;
                w_bul_y_nxt  = L_PARK;
                w_active_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset parks the bullet and clears pulses.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_dir      <= 2'd0;
            r_cnt      <= 4'd0;
            r_bul_x    <= L_PARK;
            r_bul_y    <= L_PARK;
            r_active   <= 1'b0;
            r_map_idx  <= 9'd0;
            r_brk_idx  <= 9'd0;
            r_brk_hit  <= 1'b0;
            r_tank_hit <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bul_x    <= w_bul_x_nxt;
            r_bul_y    <= w_bul_y_nxt;
            r_active   <= w_active_nxt;
            r_map_idx  <= w_map_idx_nxt;
            r_brk_idx  <= w_brk_idx_nxt;
            r_brk_hit  <= w_brk_hit_nxt;
            r_tank_hit <= w_tank_hit_nxt;
        end
    end

    assign map_rd_idx = r_map_idx;
    assign bul_x      = r_bul_x;
    assign bul_y      = r_bul_y;
    assign bul_active = r_active;
    assign brk_hit    = r_brk_hit;
    assign brk_idx    = r_brk_idx;
    assign tank_hit   = r_tank_hit;

endmodule

// File: tb/tb_bullet_controller.sv
// Self-checking bench for bullet_controller: a scoreboard of expected bullet
// events (position changes, brick hits, tank hits) with their arrival cycles,
// plus inline checks of registered outputs after each scenario.
module tb_bullet_controller;

    logic       Clk = 1'b0;
    logic       Reset_n, frame_clk, fire;
    logic [4:0] tank_x, tank_y, opp_x, opp_y;
    logic [1:0] tank_dir;
    logic [2:0] map_rd_data, map_rd_data4;
    logic [8:0] map_rd_idx, map_rd_idx4, brk_idx, brk_idx4;
    logic [4:0] bul_x, bul_y, bul_x4, bul_y4;
    logic       bul_active, brk_hit, tank_hit, bul_active4, brk_hit4, tank_hit4;

    logic [2:0] mem [0:511];

    typedef struct { int kind; int a; int b; int cyc; } ev_t;
    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic       mon_en = 1'b0;
    logic [4:0] prev_x, prev_y;

    bullet_controller #(.STEP_FRAMES(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
        .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
        .opp_x(opp_x), .opp_y(opp_y),
        .map_rd_idx(map_rd_idx), .map_rd_data(map_rd_data),
        .bul_x(bul_x), .bul_y(bul_y), .bul_active(bul_active),
        .brk_hit(brk_hit), .brk_idx(brk_idx), .tank_hit(tank_hit));

    bullet_controller #(.STEP_FRAMES(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
        .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
        .opp_x(opp_x), .opp_y(opp_y),
        .map_rd_idx(map_rd_idx4), .map_rd_data(map_rd_data4),
        .bul_x(bul_x4), .bul_y(bul_y4), .bul_active(bul_active4),
        .brk_hit(brk_hit4), .brk_idx(brk_idx4), .tank_hit(tank_hit4));

    always #5 Clk = ~Clk;

    // Map store model: one-cycle registered read.
    always @(posedge Clk) begin
        map_rd_data  <= mem[map_rd_idx];
        map_rd_data4 <= mem[map_rd_idx4];
    end

    task automatic push_ev(input int kind, input int a, input int b, input int c);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Scoreboard pop/compare for one observed DUT event.
    task automatic obs(input int kind, input int a, input int b);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: got unexpected kind=%0d a=%0d b=%0d at cyc %0d, want no event",
                     kind, a, b, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.a !== a || e.b !== b || e.cyc !== cyc)
                $display("FAIL scoreboard: got kind=%0d a=%0d b=%0d cyc=%0d, want kind=%0d a=%0d b=%0d cyc=%0d",
                         kind, a, b, cyc, e.kind, e.a, e.b, e.cyc);
            else
                n_pass++;
        end
    endtask

    // Advance n clocks, sampling outputs on the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
            if (mon_en) begin
                if (brk_hit === 1'b1)  obs(1, int'(brk_idx), 0);
                if (tank_hit === 1'b1) obs(2, 0, 0);
                if (bul_x !== prev_x || bul_y !== prev_y) obs(0, int'(bul_x), int'(bul_y));
            end
            prev_x = bul_x;
            prev_y = bul_y;
        end
    endtask

    task automatic do_fire(input logic [4:0] x, input logic [4:0] y, input logic [1:0] d);
        tank_x = x; tank_y = y; tank_dir = d;
        push_ev(0, int'(x), int'(y), cyc + 1);
        fire = 1'b1;
        step(1);
        fire = 1'b0;
    endtask

    task automatic do_tick();
        frame_clk = 1'b1;
        step(4);
        frame_clk = 1'b0;
        step(6);
    endtask

    task automatic kill();
        push_ev(0, 31, 31, cyc + 1);
        Reset_n = 1'b0;
        step(2);
        Reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; fire = 1'b1; frame_clk = 1'b0;
        tank_x = 5'd5; tank_y = 5'd5; tank_dir = 2'd1;
        step(2);
        n_checks++;
        if ({bul_x, bul_y, bul_active, brk_hit, tank_hit, brk_idx, map_rd_idx} !== {5'd31, 5'd31, 3'b000, 9'd0, 9'd0})
            $display("FAIL reset_values: got x=%0d y=%0d act=%b brk=%b tnk=%b bidx=%0d ridx=%0d, want 31 31 0 0 0 0 0",
                     bul_x, bul_y, bul_active, brk_hit, tank_hit, brk_idx, map_rd_idx);
        else n_pass++;
        Reset_n = 1'b1; fire = 1'b0;
        step(3);
        n_checks++;
        if ({bul_x, bul_y, bul_active} !== {5'd31, 5'd31, 1'b0})
            $display("FAIL reset_release_idle: got x=%0d y=%0d act=%b, want 31 31 0", bul_x, bul_y, bul_active);
        else n_pass++;
        mon_en = 1'b1;
    endtask

    task automatic test_straight();
        do_fire(5'd5, 5'd5, 2'd1);
        for (int k = 0; k < 3; k++) begin
            push_ev(0, 6 + k, 5, cyc + 5);
            do_tick();
            n_checks++;
            if (map_rd_idx !== 9'(106 + k) || bul_active !== 1'b1)
                $display("FAIL straight_idx%0d: got idx=%0d act=%b, want idx=%0d act=1", k, map_rd_idx, bul_active, 106 + k);
            else n_pass++;
        end
        kill();
    endtask

    task automatic test_brick();
        mem[107] = 3'd2;
        do_fire(5'd5, 5'd5, 2'd1);
        push_ev(0, 6, 5, cyc + 5);
        do_tick();
        push_ev(1, 107, 0, cyc + 5);
        push_ev(0, 31, 31, cyc + 5);
        do_tick();
        n_checks++;
        if ({brk_idx, bul_x, bul_active} !== {9'd107, 5'd31, 1'b0})
            $display("FAIL brick_final: got bidx=%0d x=%0d act=%b, want 107 31 0", brk_idx, bul_x, bul_active);
        else n_pass++;
        mem[107] = 3'd0;
    endtask

    task automatic test_edge();
        do_fire(5'd0, 5'd3, 2'd3);
        push_ev(0, 31, 31, cyc + 3);
        do_tick();
        n_checks++;
        if (map_rd_idx !== 9'd107 || bul_active !== 1'b0)
            $display("FAIL edge_no_read: got idx=%0d act=%b, want idx=107 act=0", map_rd_idx, bul_active);
        else n_pass++;
    endtask

    task automatic test_opponent();
        mem[46] = 3'd6;
        opp_x = 5'd7; opp_y = 5'd2;
        do_fire(5'd5, 5'd2, 2'd1);
        push_ev(0, 6, 2, cyc + 5);
        do_tick();
        n_checks++;
        if (map_rd_idx !== 9'd46 || bul_x !== 5'd6)
            $display("FAIL bush_pass: got idx=%0d x=%0d, want 46 6", map_rd_idx, bul_x);
        else n_pass++;
        push_ev(2, 0, 0, cyc + 3);
        push_ev(0, 31, 31, cyc + 3);
        do_tick();
        n_checks++;
        if (map_rd_idx !== 9'd46 || bul_active !== 1'b0)
            $display("FAIL opp_hit_final: got idx=%0d act=%b, want 46 0", map_rd_idx, bul_active);
        else n_pass++;
        opp_x = 5'd19; opp_y = 5'd14;
        mem[46] = 3'd0;
    endtask

    task automatic test_back_to_back();
        int base;
        tank_x = 5'd0; tank_y = 5'd3; tank_dir = 2'd3;
        push_ev(0, 0, 3, cyc + 1);
        fire = 1'b1;
        step(1);
        base = cyc;
        push_ev(0, 31, 31, base + 3);
        push_ev(0, 0, 3, base + 4);
        frame_clk = 1'b1;
        step(4);
        fire = 1'b0;
        frame_clk = 1'b0;
        step(6);
        push_ev(0, 31, 31, cyc + 3);
        do_tick();
        // fire held through a flight must not respawn the bullet
        tank_x = 5'd5; tank_y = 5'd5; tank_dir = 2'd1;
        push_ev(0, 5, 5, cyc + 1);
        fire = 1'b1;
        step(1);
        push_ev(0, 6, 5, cyc + 5);
        do_tick();
        tank_x = 5'd10;
        push_ev(0, 7, 5, cyc + 5);
        do_tick();
        fire = 1'b0;
        kill();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL refire_pending: got %0d unseen events, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_read();
        int base;
        mem[106] = 3'd2;
        do_fire(5'd5, 5'd5, 2'd1);
        base = cyc;
        push_ev(0, 31, 31, base + 4);
        frame_clk = 1'b1;
        step(3);
        Reset_n = 1'b0;
        frame_clk = 1'b0;
        step(2);
        Reset_n = 1'b1;
        step(8);
        n_checks++;
        if ({brk_hit, bul_active, bul_x, brk_idx, map_rd_idx} !== {1'b0, 1'b0, 5'd31, 9'd0, 9'd0})
            $display("FAIL reset_mid_read: got brk=%b act=%b x=%0d bidx=%0d ridx=%0d, want 0 0 31 0 0",
                     brk_hit, bul_active, bul_x, brk_idx, map_rd_idx);
        else n_pass++;
        mem[106] = 3'd0;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL events_pending: got %0d unseen events, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_rate();
        mon_en = 1'b0;
        Reset_n = 1'b0;
        step(2);
        Reset_n = 1'b1;
        tank_x = 5'd5; tank_y = 5'd5; tank_dir = 2'd1;
        fire = 1'b1;
        step(1);
        fire = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            n_checks++;
            if (bul_x4 !== 5'(5 + k / 4) || bul_y4 !== 5'd5)
                $display("FAIL rate_tick%0d: got x=%0d y=%0d, want x=%0d y=5", k, bul_x4, bul_y4, 5 + k / 4);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 3'd0;
        opp_x = 5'd19; opp_y = 5'd14;
        prev_x = 5'd31; prev_y = 5'd31;
        test_reset();
        test_straight();
        test_brick();
        test_edge();
        test_opponent();
        test_back_to_back();
        test_reset_read();
        test_rate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
